// File: rtl/uart_frame_pkg.sv
// Shared constants for the voltage-report line format ("Vnn - dddd V" LF CR),
// used by both the formatter and the receive-side parser.
package uart_frame_pkg;

    localparam logic [7:0] CHAR_V    = 8'h56;
    localparam logic [7:0] CHAR_SP   = 8'h20;
    localparam logic [7:0] CHAR_DASH = 8'h2D;
    localparam logic [7:0] CHAR_LF   = 8'h0A;
    localparam logic [7:0] CHAR_CR   = 8'h0D;
    localparam logic [7:0] CHAR_0    = 8'h30;

    localparam int FRAME_LEN = 14;

    // Each frame state equals the index of the byte it expects next.
    localparam logic [3:0] S_HUNT  = 4'd0;
    localparam logic [3:0] S_CH_T  = 4'd1;
    localparam logic [3:0] S_CH_U  = 4'd2;
    localparam logic [3:0] S_SP1   = 4'd3;
    localparam logic [3:0] S_DASH  = 4'd4;
    localparam logic [3:0] S_SP2   = 4'd5;
    localparam logic [3:0] S_DG3   = 4'd6;
    localparam logic [3:0] S_DG2   = 4'd7;
    localparam logic [3:0] S_DG1   = 4'd8;
    localparam logic [3:0] S_DG0   = 4'd9;
    localparam logic [3:0] S_SP3   = 4'd10;
    localparam logic [3:0] S_V_END = 4'd11;
    localparam logic [3:0] S_LF    = 4'd12;
    localparam logic [3:0] S_CR    = 4'd13;

endpackage

// File: rtl/uart_ascii_digit.sv
// Classifies one ASCII byte as a decimal digit and returns its value.
module uart_ascii_digit
    import uart_frame_pkg::*;
(
    input  logic [7:0] data,
    output logic       is_digit,
    output logic [3:0] nibble
);

    logic [7:0] offset;

    // Bytes below '0' wrap to large values, so one compare covers both ends.
    assign offset   = data - CHAR_0;
    assign is_digit = (offset < 8'd10);
    assign nibble   = offset[3:0];

endmodule

// File: rtl/uart_frame_parser.sv
// Parses 14-byte voltage-report lines from the UART RX byte stream into a
// channel number and BCD reading, flagging malformed and stalled frames.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int MAX_CHANNEL    = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_tick,
    output logic [3:0]  channel,
    output logic [15:0] value,
    output logic        valid,
    output logic        error,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
);

    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

    logic [3:0]    state_reg, state_next;
    logic [IW-1:0] idle_reg, idle_next;
    logic [3:0]    tens_reg, tens_next;
    logic [3:0]    shadow_ch_reg, shadow_ch_next;
    logic [15:0]   shadow_val_reg, shadow_val_next;
    logic [3:0]    channel_reg, channel_next;
    logic [15:0]   value_reg, value_next;
    logic          valid_reg, valid_next;
    logic          error_reg, error_next;
    logic [15:0]   frame_cnt_reg, frame_cnt_next;
    logic [7:0]    err_cnt_reg, err_cnt_next;

    logic       is_digit;
    logic [3:0] nibble;
    logic [6:0] ch_calc;
    logic       byte_ok;

    uart_ascii_digit u_digit (
        .data     (rx_data),
        .is_digit (is_digit),
        .nibble   (nibble)
    );

    assign ch_calc = ({3'b000, tens_reg} * 7'd10) + {3'b000, nibble};

    always_comb begin
        byte_ok = 1'b0;
        case (state_reg)
            S_CH_T, S_DG3, S_DG2, S_DG1, S_DG0: byte_ok = is_digit;
            S_CH_U: byte_ok = is_digit && (ch_calc != 7'd0) && (ch_calc <= 7'(MAX_CHANNEL));
            S_SP1, S_SP2, S_SP3: byte_ok = (rx_data == CHAR_SP);
            S_DASH:  byte_ok = (rx_data == CHAR_DASH);
            S_V_END: byte_ok = (rx_data == CHAR_V);
            S_LF:    byte_ok = (rx_data == CHAR_LF);
            S_CR:    byte_ok = (rx_data == CHAR_CR);
            default: byte_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        idle_next       = idle_reg;
        tens_next       = tens_reg;
        shadow_ch_next  = shadow_ch_reg;
        shadow_val_next = shadow_val_reg;
        channel_next    = channel_reg;
        value_next      = value_reg;
        valid_next      = 1'b0;
        error_next      = 1'b0;
        frame_cnt_next  = frame_cnt_reg;
        err_cnt_next    = err_cnt_reg;

        if (rx_tick) begin
            // A byte always restarts the idle window, even on the expiry cycle.
            idle_next = '0;
            if (state_reg == S_HUNT) begin
                if (rx_data == CHAR_V) begin
                    state_next = S_CH_T;
                end
            end else if (byte_ok) begin
                case (state_reg)
                    S_CH_T: tens_next = nibble;
                    S_CH_U: shadow_ch_next = ch_calc[3:0];
                    S_DG3, S_DG2, S_DG1, S_DG0:
                        shadow_val_next = {shadow_val_reg[11:0], nibble};
                    default: ;
                endcase
                if (state_reg == S_CR) begin
                    channel_next   = shadow_ch_reg;
                    value_next     = shadow_val_reg;
                    valid_next     = 1'b1;
                    frame_cnt_next = frame_cnt_reg + 16'd1;
                    state_next     = S_HUNT;
                end else begin
                    state_next = state_reg + 4'd1;
                end
            end else begin
                error_next   = 1'b1;
                err_cnt_next = (err_cnt_reg == 8'hFF) ? 8'hFF : err_cnt_reg + 8'd1;
                // A stray 'V' is taken as the start of the next line.
                state_next   = (rx_data == CHAR_V) ? S_CH_T : S_HUNT;
            end
        end else if (state_reg != S_HUNT) begin
            if (idle_reg == IDLE_LAST) begin
                idle_next    = '0;
                error_next   = 1'b1;
                err_cnt_next = (err_cnt_reg == 8'hFF) ? 8'hFF : err_cnt_reg + 8'd1;
                state_next   = S_HUNT;
            end else begin
                idle_next = idle_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_HUNT;
            idle_reg       <= '0;
            tens_reg       <= '0;
            shadow_ch_reg  <= '0;
            shadow_val_reg <= '0;
            channel_reg    <= '0;
            value_reg      <= '0;
            valid_reg      <= 1'b0;
            error_reg      <= 1'b0;
            frame_cnt_reg  <= '0;
            err_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            idle_reg       <= idle_next;
            tens_reg       <= tens_next;
            shadow_ch_reg  <= shadow_ch_next;
            shadow_val_reg <= shadow_val_next;
            channel_reg    <= channel_next;
            value_reg      <= value_next;
            valid_reg      <= valid_next;
            error_reg      <= error_next;
            frame_cnt_reg  <= frame_cnt_next;
            err_cnt_reg    <= err_cnt_next;
        end
    end

    assign channel   = channel_reg;
    assign value     = value_reg;
    assign valid     = valid_reg;
    assign error     = error_reg;
    assign frame_cnt = frame_cnt_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Drives byte streams into uart_frame_parser and compares every cycle against
// a line-template model of the report format.
module tb_uart_frame_parser;

    localparam int TO = 100;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_tick = 1'b0;
    logic [3:0]  channel;
    logic [15:0] value;
    logic        valid;
    logic        error;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    uart_frame_parser #(.TIMEOUT_CYCLES(TO), .MAX_CHANNEL(14)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_tick   (rx_tick),
        .channel   (channel),
        .value     (value),
        .valid     (valid),
        .error     (error),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit armed = 1'b0;

    // Reference model: the line collected so far is checked against a template.
    string      tmpl = "V## - #### V\n\r";
    logic [7:0] line[$];
    int         idle_m = 0;
    logic [3:0]  exp_channel = '0;
    logic [15:0] exp_value = '0;
    logic        exp_valid = 1'b0;
    logic        exp_error = 1'b0;
    logic [15:0] exp_frame_cnt = '0;
    logic [7:0]  exp_err_cnt = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dval(input logic [7:0] b);
        return int'(b) - 48;
    endfunction

    task automatic model_abort();
        exp_error = 1'b1;
        if (exp_err_cnt != 8'd255) exp_err_cnt++;
        line.delete();
        idle_m = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int  idx;
        int  ch;
        bit  ok;
        byte t;
        if (line.size() == 0) begin
            if (b == "V") line.push_back(b);
            return;
        end
        idx = line.size();
        t = tmpl[idx];
        ok = (t == "#") ? (b >= "0" && b <= "9") : (b == 8'(t));
        if (ok && idx == 2) begin
            ch = dval(line[1]) * 10 + dval(b);
            ok = (ch >= 1) && (ch <= 14);
        end
        if (!ok) begin
            model_abort();
            if (b == "V") line.push_back(b);
            return;
        end
        line.push_back(b);
        if (line.size() == 14) begin
            exp_valid     = 1'b1;
            exp_channel   = 4'(dval(line[1]) * 10 + dval(line[2]));
            exp_value     = {4'(dval(line[6])), 4'(dval(line[7])), 4'(dval(line[8])), 4'(dval(line[9]))};
            exp_frame_cnt = exp_frame_cnt + 16'd1;
            line.delete();
        end
    endtask

    // One clock: check what the previous edge produced, then present new inputs.
    task automatic step(input logic r, input logic t, input logic [7:0] d);
        logic [7:0] dd;
        @(negedge clk);
        if (armed) begin
            check("valid", valid, exp_valid);
            check("error", error, exp_error);
            check("channel", channel, exp_channel);
            check("value", value, exp_value);
            check("frame_cnt", frame_cnt, exp_frame_cnt);
            check("err_cnt", err_cnt, exp_err_cnt);
        end
        armed = 1'b1;
        exp_valid = 1'b0;
        exp_error = 1'b0;
        dd = t ? d : 8'($urandom);
        if (r) begin
            line.delete();
            idle_m = 0;
            exp_channel = '0;
            exp_value = '0;
            exp_frame_cnt = '0;
            exp_err_cnt = '0;
        end else if (t) begin
            idle_m = 0;
            model_byte(d);
        end else if (line.size() > 0) begin
            idle_m++;
            if (idle_m == TO) model_abort();
        end
        rst = r;
        rx_tick = t;
        rx_data = dd;
    endtask

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
        return q;
    endfunction

    function automatic bq_t mk_frame(input int ch, input logic [15:0] bcd);
        return str2q($sformatf("V%02d - %04h V\n\r", ch, bcd));
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v = '0;
        for (int k = 0; k < 4; k++) v = {v[11:0], 4'($urandom_range(0, 9))};
        return v;
    endfunction

    task automatic send(input bq_t q, input int first, input int last, input int gap);
        for (int i = first; i <= last && i < q.size(); i++) begin
            step(1'b0, 1'b1, q[i]);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 8'h00);
        end
        $display("tx bytes[%0d..%0d] gap=%0d frame_cnt_exp=%0d err_cnt_exp=%0d",
                 first, last, gap, exp_frame_cnt, exp_err_cnt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        bq_t q;
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        idle(3);

        // Single slow frame
        send(mk_frame(7, 16'h1234), 0, 13, 9);
        idle(3);

        // Channels 1..14 on consecutive cycles
        for (int c = 1; c <= 14; c++) send(mk_frame(c, rand_bcd()), 0, 13, 0);
        idle(3);

        // Out-of-range channels
        send(mk_frame(15, 16'h0000), 0, 13, 1);
        send(mk_frame(0, 16'h0000), 0, 13, 1);
        idle(3);

        // Truncated frame resynchronised by the next frame's 'V'
        send(str2q("V03 - 12"), 0, 7, 0);
        send(mk_frame(4, 16'h5678), 0, 13, 0);
        idle(3);

        // Timeout expiry, then a byte landing exactly on the expiry cycle
        send(str2q("V05 -"), 0, 4, 0);
        idle(TO + 10);
        send(str2q("V05 -"), 0, 4, 0);
        idle(TO - 1);
        send(str2q(" "), 0, 0, 0);
        idle(5);
        step(1'b1, 1'b0, 8'h00);
        idle(3);

        // Reset mid-frame, tail of that frame, then a clean frame
        q = mk_frame(9, 16'h4321);
        send(q, 0, 7, 0);
        step(1'b1, 1'b0, 8'h00);
        send(q, 8, 10, 0);
        idle(3);
        send(mk_frame(2, 16'h9087), 0, 13, 0);
        idle(3);

        // Random mix of good, corrupted, truncated and garbage traffic
        for (int it = 0; it < 80; it++) begin
            int kind = $urandom_range(0, 3);
            q = mk_frame($urandom_range(1, 14), rand_bcd());
            case (kind)
                0: send(q, 0, 13, $urandom_range(0, 2));
                1: begin
                    q[$urandom_range(1, 13)] = 8'($urandom_range(0, 255));
                    send(q, 0, 13, $urandom_range(0, 1));
                end
                2: begin
                    send(q, 0, $urandom_range(0, 12), 0);
                    idle($urandom_range(TO - 3, TO + 3));
                end
                default: begin
                    q.delete();
                    for (int k = 0; k < 6; k++) q.push_back(8'($urandom_range(0, 255)));
                    send(q, 0, 5, $urandom_range(0, 1));
                end
            endcase
        end
        idle(TO + 5);

        // Saturate the error counter with a run of 'V' bytes
        q.delete();
        for (int k = 0; k < 300; k++) q.push_back(8'h56);
        send(q, 0, 299, 0);
        send(mk_frame(11, 16'h0042), 0, 13, 0);
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
